// File: rtl/univ_shreg_pkg.sv
// Shared types for the universal shift register: op codes, FSM states and
// the per-bit source select used by every shreg_slice.
package univ_shreg_pkg;

    localparam int SHREG_OP_W = 3;

    typedef enum logic [SHREG_OP_W-1:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ASR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_RSVD = 3'b111
    } shreg_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } shreg_state_e;

    // lo = take the bit below (shift toward MSB), hi = take the bit above
    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_LO   = 2'b10,
        SEL_HI   = 2'b11
    } slice_sel_e;

endpackage

// File: rtl/shreg_slice.sv
// One bit of the universal shift register: next-value mux plus async-reset flop.
// Edge bits receive their fill/serial/rotate sources on lo/hi from the top level.
module shreg_slice
    import univ_shreg_pkg::*;
(
    input  logic       c,
    input  logic       nrst,
    input  slice_sel_e sel,
    input  logic       ld,
    input  logic       lo,
    input  logic       hi,
    output logic       q
);

    always_ff @(posedge c or negedge nrst) begin
        if (!nrst) begin
            q <= 1'b0;
        end else begin
            case (sel)
                SEL_LOAD: q <= ld;
                SEL_LO:   q <= lo;
                SEL_HI:   q <= hi;
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/univ_shreg.sv
// Universal shift register, one bit position per clock under start/busy/done.
// Rotates are built only when UNIV_SHREG_ROTATE_EN is defined; otherwise ROL/ROR act as HOLD.
module univ_shreg
    import univ_shreg_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = $clog2(W + 1)
) (
    input  logic                  c,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [SHREG_OP_W-1:0] op,
    input  logic [AW-1:0]         amt,
    input  logic [W-1:0]          d,
    input  logic                  si_l,
    input  logic                  si_r,
    output logic [W-1:0]          q,
    output logic                  so_l,
    output logic                  so_r,
    output logic                  busy,
    output logic                  done
);

    shreg_state_e state, state_nx;
    shreg_op_e    op_in, op_r, op_r_nx;
    logic [AW-1:0] cnt, cnt_nx, amt_eff;
    logic          done_nx;
    logic          step_op;
    slice_sel_e    sel;
    logic [W-1:0]  lo_src, hi_src;

    assign op_in   = shreg_op_e'(op);
    assign amt_eff = (amt > AW'(W)) ? AW'(W) : amt;

    always_comb begin
        step_op = 1'b0;
        case (op_in)
            OP_SHL, OP_SHR, OP_ASR: step_op = 1'b1;
`ifdef UNIV_SHREG_ROTATE_EN
            OP_ROL, OP_ROR:         step_op = 1'b1;
`endif
            default:                step_op = 1'b0;
        endcase
    end

    always_ff @(posedge c or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_r  <= OP_HOLD;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op_r  <= op_r_nx;
            done  <= done_nx;
        end
    end

    // The edge that consumes the last pending step also raises done
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_r_nx  = op_r;
        done_nx  = 1'b0;
        sel      = SEL_HOLD;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    op_r_nx = op_in;
                    if (op_in == OP_LOAD) begin
                        sel = SEL_LOAD;
                    end
                    if (step_op && (amt_eff != '0)) begin
                        cnt_nx   = amt_eff;
                        state_nx = ST_RUN;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_nx = cnt - AW'(1);
                case (op_r)
                    OP_SHL:         sel = SEL_LO;
                    OP_SHR, OP_ASR: sel = SEL_HI;
`ifdef UNIV_SHREG_ROTATE_EN
                    OP_ROL:         sel = SEL_LO;
                    OP_ROR:         sel = SEL_HI;
`endif
                    default:        sel = SEL_HOLD;
                endcase
                if (cnt == AW'(1)) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Interior bits see their neighbours; only the two edge bits need a source choice
    always_comb begin
        lo_src = {q[W-2:0], si_l};
        hi_src = {si_r, q[W-1:1]};
        case (op_r)
            OP_ASR:  hi_src[W-1] = q[W-1];
`ifdef UNIV_SHREG_ROTATE_EN
            OP_ROL:  lo_src[0]   = q[W-1];
            OP_ROR:  hi_src[W-1] = q[0];
`endif
            default: ;
        endcase
    end

    for (genvar i = 0; i < W; i++) begin : g_slice
        shreg_slice u_slice (
            .c    (c),
            .nrst (nrst),
            .sel  (sel),
            .ld   (d[i]),
            .lo   (lo_src[i]),
            .hi   (hi_src[i]),
            .q    (q[i])
        );
    end

    assign busy = (state == ST_RUN);
    assign so_l = q[W-1];
    assign so_r = q[0];

endmodule
